// File: rtl/result_ascii_tx_pkg.sv
// result_ascii_tx_pkg: ASCII constants, FSM states and BCD sizing helper
package result_ascii_tx_pkg;
   localparam logic [7:0] CH_ZERO = 8'h30;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_LF = 8'h0A;
   typedef enum logic [2:0] {IDLE, CONVERT, EMIT_SIGN, EMIT_DIGIT, EMIT_NL} state_t;
   // smallest d with 10^d >= 2^w, i.e. enough digits for 2^w - 1
   function automatic int min_digits(input int w);
      int d = 1;
      for (longint p = 10; p < (longint'(1) << w); p = p * 10) d++;
      return d;
   endfunction
   function automatic logic [7:0] ascii_digit(input logic [3:0] n);
      return CH_ZERO + {4'd0, n};
   endfunction
endpackage

// File: rtl/result_ascii_tx_if.sv
// result_ascii_tx_if: value-in and character-out handshakes
interface result_ascii_tx_if #(parameter int W = 6);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] value_in;
   logic         neg_in;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_char;
   logic         busy;
   modport master (output in_valid, value_in, neg_in, out_ready,
                   input in_ready, out_valid, out_char, busy);
   modport slave (input in_valid, value_in, neg_in, out_ready,
                  output in_ready, out_valid, out_char, busy);
endinterface

// File: rtl/result_ascii_tx_dabble.sv
// bcd_dabble_step: add-3 correction on every nibble, then shift in one binary bit
module bcd_dabble_step #(parameter int DIGITS = 2) (
   input  logic [4*DIGITS-1:0] bcd_in,
   input  logic                bit_in,
   output logic [4*DIGITS-1:0] bcd_out
);
   logic [4*DIGITS-1:0] adj;
   for (genvar g = 0; g < DIGITS; g++) begin : g_nib
      assign adj[4*g +: 4] = bcd_in[4*g +: 4] >= 4'd5 ? bcd_in[4*g +: 4] + 4'd3 : bcd_in[4*g +: 4];
   end
   assign bcd_out = (adj << 1) | {{(4*DIGITS-1){1'b0}}, bit_in};
endmodule

// File: rtl/result_ascii_tx.sv
// result_ascii_tx: serial double-dabble binary-to-decimal ASCII emitter
// Emits optional '-', digits without leading zeros, then LF.
module result_ascii_tx
   import result_ascii_tx_pkg::*;
#(
   parameter int W = 6,
   parameter int DIGITS = 2
) (
   input logic clk,
   input logic rst_n,
   result_ascii_tx_if.slave bus
);
   localparam int BW = 4 * DIGITS;
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(W + 1);
   if (DIGITS < min_digits(W)) begin : g_bad_digits
      $error("DIGITS too small for W");
   end
   state_t state;
   logic [BW-1:0] bcd, nxt, src;
   logic [W-1:0] bin;
   logic neg, vld, acc;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx, top, prv;
   logic [7:0] chr;
   bcd_dabble_step #(.DIGITS(DIGITS)) u_step (.bcd_in(bcd), .bit_in(bin[W-1]), .bcd_out(nxt));
   // on the last CONVERT step the leading digit must come from the step result
   assign src = state == CONVERT ? nxt : bcd;
   always_comb begin
      top = '0;
      for (int i = 0; i < DIGITS; i++) if (src[4*i +: 4] != 4'd0) top = IW'(i);
   end
   assign prv = idx - 1'b1;
   assign acc = vld & bus.out_ready;
   assign bus.in_ready = state == IDLE;
   assign bus.busy = state != IDLE;
   assign bus.out_valid = vld;
   assign bus.out_char = chr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         bcd <= '0;
         bin <= '0;
         neg <= 1'b0;
         cnt <= '0;
         idx <= '0;
         vld <= 1'b0;
         chr <= 8'h00;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               bin <= bus.value_in;
               bcd <= '0;
               neg <= bus.neg_in;
               cnt <= CW'(W);
               state <= CONVERT;
            end
            CONVERT: begin
               bcd <= nxt;
               bin <= bin << 1;
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  vld <= 1'b1;
                  idx <= top;
                  chr <= neg ? CH_MINUS : ascii_digit(nxt[4*top +: 4]);
                  state <= neg ? EMIT_SIGN : EMIT_DIGIT;
               end
            end
            EMIT_SIGN: if (acc) begin
               idx <= top;
               chr <= ascii_digit(bcd[4*top +: 4]);
               state <= EMIT_DIGIT;
            end
            EMIT_DIGIT: if (acc) begin
               idx <= idx == '0 ? idx : prv;
               chr <= idx == '0 ? CH_LF : ascii_digit(bcd[4*prv +: 4]);
               state <= idx == '0 ? EMIT_NL : EMIT_DIGIT;
            end
            EMIT_NL: if (acc) begin
               vld <= 1'b0;
               chr <= 8'h00;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
